// File: rtl/booth_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and digit-map constants for the radix-4 Booth core
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    typedef struct packed {
        logic single;
        logic dbl;
        logic neg;
    } booth_digit_t;

    // Selector encodings as {single, dbl, neg}
    localparam booth_digit_t c_DIGIT_ZERO = 3'b000;
    localparam booth_digit_t c_DIGIT_P1   = 3'b100;
    localparam booth_digit_t c_DIGIT_P2   = 3'b010;
    localparam booth_digit_t c_DIGIT_M1   = 3'b101;
    localparam booth_digit_t c_DIGIT_M2   = 3'b011;

endpackage
`default_nettype wire

// File: rtl/booth_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : booth_encoder
// Description : Radix-4 Booth recoder, multiplier triplet -> selector signals
// Revision    : 1.0 - initial release
// ============================================================================
module booth_encoder
    import booth_pkg::*;
(
    input  logic [2:0]   i_triplet,
    output booth_digit_t o_digit
);

    always_comb begin
        o_digit = c_DIGIT_ZERO;
        case (i_triplet)
            3'b001, 3'b010: o_digit = c_DIGIT_P1;
            3'b011:         o_digit = c_DIGIT_P2;
            3'b100:         o_digit = c_DIGIT_M2;
            3'b101, 3'b110: o_digit = c_DIGIT_M1;
            default:        o_digit = c_DIGIT_ZERO;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_radix4_seq_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : booth_radix4_seq_multiplier
// Description : Iterative signed radix-4 Booth multiplier, one digit per clock
// Revision    : 1.0 - initial release
// ============================================================================
module booth_radix4_seq_multiplier
    import booth_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic             busy
);

    localparam int c_ITER  = N / 2;
    localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;
    localparam int c_ACC_W = 2 * N + 2;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITER - 1);

    booth_state_t         r_state_q,     w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q,       w_cnt_d;
    logic [N-1:0]         r_mcand_q,     w_mcand_d;
    logic [N:0]           r_mplr_q,      w_mplr_d;
    logic [c_ACC_W-1:0]   r_acc_q,       w_acc_d;
    logic                 r_in_ready_q,  w_in_ready_d;
    logic                 r_out_valid_q, w_out_valid_d;
    logic                 r_busy_q,      w_busy_d;
    logic [2*N-1:0]       r_product_q,   w_product_d;

    booth_digit_t         w_digit;
    logic [N+1:0]         w_pp_mag;
    logic [N+1:0]         w_pp;
    logic [N+1:0]         w_acc_hi;
    logic [c_ACC_W-1:0]   w_acc_step;

    // Low bit of r_mplr_q is the implicit b[-1]; the register shifts right by 2 per digit
    booth_encoder u_encoder (
        .i_triplet (r_mplr_q[2:0]),
        .o_digit   (w_digit)
    );

    // The accumulator holds P_i * 2^(N-2i): adding the digit at bit N then
    // shifting right by 2 lands the final product exactly at ACC[2N-1:0].
    always_comb begin
        w_pp_mag = '0;
        if (w_digit.single) begin
            w_pp_mag = {{2{r_mcand_q[N-1]}}, r_mcand_q};
        end else if (w_digit.dbl) begin
            w_pp_mag = {r_mcand_q[N-1], r_mcand_q, 1'b0};
        end
        w_pp       = w_digit.neg ? ~w_pp_mag : w_pp_mag;
        w_acc_hi   = r_acc_q[c_ACC_W-1:N] + w_pp + {{(N+1){1'b0}}, w_digit.neg};
        w_acc_step = {{2{w_acc_hi[N+1]}}, w_acc_hi, r_acc_q[N-1:2]};
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_mcand_d     = r_mcand_q;
        w_mplr_d      = r_mplr_q;
        w_acc_d       = r_acc_q;
        w_out_valid_d = r_out_valid_q;
        w_product_d   = r_product_q;

        case (r_state_q)
            IDLE: begin
                if (in_valid && r_in_ready_q) begin
                    w_state_d = CALC;
                    w_mcand_d = a;
                    w_mplr_d  = {b, 1'b0};
                    w_acc_d   = '0;
                end
            end
            CALC: begin
                w_acc_d  = w_acc_step;
                w_mplr_d = {2'b00, r_mplr_q[N:2]};
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            DONE: begin
                // First DONE cycle captures the result; out_ready only counts once valid is up
                if (!r_out_valid_q) begin
                    w_out_valid_d = 1'b1;
                    w_product_d   = r_acc_q[2*N-1:0];
                end else if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        w_in_ready_d = (w_state_d == IDLE);
        w_busy_d     = (w_state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= '0;
            r_mcand_q     <= '0;
            r_mplr_q      <= '0;
            r_acc_q       <= '0;
            r_in_ready_q  <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_product_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_mcand_q     <= w_mcand_d;
            r_mplr_q      <= w_mplr_d;
            r_acc_q       <= w_acc_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_busy_q      <= w_busy_d;
            r_product_q   <= w_product_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign busy      = r_busy_q;
    assign product   = r_product_q;

endmodule
`default_nettype wire
